// File: rtl/prio_pkg.sv
// Shared types and helpers for the registered N-channel priority encoder.
// Holds the state encoding, the code-width helper and the active-low code formatter.
package prio_pkg;

  localparam int MAX_W = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic int W_OF(input int n);
    return $clog2(n);
  endfunction

  function automatic logic [MAX_W-1:0] enc_n(input logic [MAX_W-1:0] idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/prio_encoder_n_if.sv
// Request/grant bundle between the request sources, the encoder and its single consumer.
// Master drives requests, controls and ack; slave returns the active-low grant code and flags.
interface prio_encoder_n_if
  import prio_pkg::*;
#(
  parameter int N = 8
);
  localparam int W = W_OF(N);

  logic         ei_n;
  logic [N-1:0] din_n;
  logic [N-1:0] mask;
  logic         mode;
  logic         ack;
  logic [W-1:0] dout_n;
  logic         gs_n;
  logic         eo_n;

  modport master (
    output ei_n, din_n, mask, mode, ack,
    input  dout_n, gs_n, eo_n
  );

  modport slave (
    input  ei_n, din_n, mask, mode, ack,
    output dout_n, gs_n, eo_n
  );
endinterface

// File: rtl/prio_pick.sv
// Combinational rotate-search picker: highest-priority set bit, descending from ptr-1 mod N.
// Zero latency; no backpressure.
module prio_pick
  import prio_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  input  logic [W_OF(N)-1:0]   ptr,
  output logic                 hit,
  output logic [W_OF(N)-1:0]   idx
);
  localparam int W = W_OF(N);

  logic [W-1:0] j;

  // Walk from the lowest priority slot upwards so the nearest (k = 0) hit wins.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    j   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = ptr - W'(1) - W'(k);
      if (req[j]) begin
        hit = 1'b1;
        idx = j;
      end
    end
  end

endmodule

// File: rtl/prio_encoder_n.sv
// Registered N-channel priority encoder: latches request falling edges, grants one at a time.
// Latency: request->grant 2 edges, ack->next grant 1 edge; backpressure: grant frozen until ack.
module prio_encoder_n
  import prio_pkg::*;
#(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  prio_encoder_n_if.slave  bus
);
  localparam int W = W_OF(N);

  logic [N-1:0] din_q;
  logic [N-1:0] pending;
  logic [N-1:0] rise;
  logic [N-1:0] acc_oh;
  logic [N-1:0] eligible;
  logic [W-1:0] ptr_q;
  logic [W-1:0] g_q;
  logic [W-1:0] g_d;
  logic [W-1:0] pick_ptr;
  logic [W-1:0] pick_idx;
  logic         pick_hit;
  logic         acc;
  logic         eo_q;
  logic         eo_d;
  state_t       state_q;
  state_t       state_d;

  assign rise     = din_q & ~bus.din_n;
  assign acc      = (state_q == GRANT) && bus.ack && !bus.ei_n;
  assign acc_oh   = acc ? (N'(1) << g_q) : '0;
  assign eligible = pending & ~bus.mask & ~acc_oh;
  // Back-to-back re-arbitration rotates from the grant being retired this edge.
  assign pick_ptr = bus.mode ? (acc ? g_q : ptr_q) : '0;

  prio_pick #(.N(N)) u_pick (
    .req (eligible),
    .ptr (pick_ptr),
    .hit (pick_hit),
    .idx (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      din_q   <= '1;
      pending <= '0;
      ptr_q   <= '0;
    end else begin
      din_q   <= bus.din_n;
      pending <= (pending & ~acc_oh) | rise;
      if (acc) ptr_q <= g_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      eo_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      eo_q    <= eo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    if (bus.ei_n) begin
      state_d = IDLE;
    end else if (state_q == IDLE || bus.ack) begin
      if (pick_hit) begin
        state_d = GRANT;
        g_d     = pick_idx;
      end else begin
        state_d = IDLE;
      end
    end
    eo_d = !(!bus.ei_n && (eligible == '0) && (state_d != GRANT));
  end

  always_comb begin
    bus.gs_n   = (state_q != GRANT);
    bus.dout_n = (state_q == GRANT) ? W'(enc_n(MAX_W'(g_q))) : '1;
    bus.eo_n   = eo_q;
  end

endmodule

// File: tb/tb_prio_encoder_n.sv
// Scoreboard bench for prio_encoder_n (N = 8): directed scenarios then randomized traffic.
module tb_prio_encoder_n;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;

  prio_encoder_n_if #(.N(N)) bus ();

  prio_encoder_n #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] dout;
    logic       gs;
    logic       eo;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  int    cycle  = 0;
  string phase  = "init";

  logic [N-1:0] m_din_q;
  logic [N-1:0] m_pend;
  int           m_ptr;
  bit           m_gr;
  int           m_g;
  bit           m_eo;

  // Reference search order: ptr-1 down to 0, then N-1 down to ptr.
  function automatic int arb(input logic [N-1:0] elig, input int p);
    for (int i = p - 1; i >= 0; i--) if (elig[i]) return i;
    for (int i = N - 1; i >= p; i--) if (elig[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin : model
    bit           en, acc;
    int           p, pk, old_g;
    logic [N-1:0] elig, nxt;
    exp_t         e;
    cycle++;
    if (rst) begin
      m_din_q = '1;
      m_pend  = '0;
      m_ptr   = 0;
      m_gr    = 0;
      m_g     = 0;
      m_eo    = 1;
    end else begin
      en    = !bus.ei_n;
      acc   = en && m_gr && bus.ack;
      old_g = m_g;
      elig  = m_pend & ~bus.mask;
      nxt   = m_pend;
      if (acc) begin
        elig[m_g] = 1'b0;
        nxt[m_g]  = 1'b0;
      end
      for (int i = 0; i < N; i++) if (m_din_q[i] && !bus.din_n[i]) nxt[i] = 1'b1;
      if (!en) begin
        m_gr = 0;
      end else if (!m_gr || acc) begin
        p  = bus.mode ? (acc ? old_g : m_ptr) : 0;
        pk = arb(elig, p);
        if (pk >= 0) begin
          m_gr = 1;
          m_g  = pk;
        end else begin
          m_gr = 0;
        end
      end
      if (acc) m_ptr = old_g;
      m_eo    = !(en && elig == '0 && !m_gr);
      m_pend  = nxt;
      m_din_q = bus.din_n;
    end
    e.dout = m_gr ? ~(3'(m_g)) : 3'b111;
    e.gs   = !m_gr;
    e.eo   = m_eo;
    sb.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.dout_n !== e.dout || bus.gs_n !== e.gs || bus.eo_n !== e.eo) begin
        errors++;
        $display("FAIL out[%s] cycle %0d: got dout_n=%b gs_n=%b eo_n=%b, expected dout_n=%b gs_n=%b eo_n=%b",
                 phase, cycle, bus.dout_n, bus.gs_n, bus.eo_n, e.dout, e.gs, e.eo);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse(input logic [N-1:0] ch);
    bus.din_n = ~ch;
    cyc(1);
    bus.din_n = '1;
  endtask

  initial begin
    rst = 1'b1;
    bus.ei_n = 1'b1; bus.din_n = '1; bus.mask = '0; bus.mode = 1'b0; bus.ack = 1'b0;

    phase = "reset";
    cyc(2);
    rst = 1'b0; bus.ei_n = 1'b0;
    cyc(2);

    phase = "fixed";
    bus.din_n = 8'b0101_0101;
    cyc(3);
    bus.ack = 1'b1;
    cyc(6);
    bus.ack = 1'b0; bus.din_n = '1;
    cyc(1);

    phase = "hold";
    pulse(8'h08);
    cyc(2);
    pulse(8'h40);
    cyc(3);
    bus.ack = 1'b1; cyc(1);
    bus.ack = 1'b0; cyc(2);
    bus.ack = 1'b1; cyc(1);
    bus.ack = 1'b0; cyc(1);

    phase = "rr";
    bus.mode = 1'b1;
    pulse(8'h81);
    cyc(2);
    bus.ack = 1'b1; bus.din_n = ~8'h80; cyc(1);
    bus.ack = 1'b0; bus.din_n = '1; cyc(2);
    bus.ack = 1'b1; cyc(1);
    bus.ack = 1'b0; cyc(2);
    bus.ack = 1'b1; cyc(1);
    bus.ack = 1'b0; bus.mode = 1'b0; cyc(1);

    phase = "mask";
    bus.mask = 8'h80;
    pulse(8'h81);
    cyc(3);
    bus.mask = 8'h00; bus.ack = 1'b1; cyc(1);
    bus.ack = 1'b0; cyc(2);
    bus.ack = 1'b1; cyc(1);
    bus.ack = 1'b0; cyc(1);

    phase = "disable";
    pulse(8'h20);
    cyc(2);
    bus.ei_n = 1'b1; bus.ack = 1'b1; cyc(2);
    bus.ei_n = 1'b0; bus.ack = 1'b0; cyc(2);
    bus.ack = 1'b1; cyc(1);
    bus.ack = 1'b0;
    pulse(8'h04);
    cyc(2);
    bus.ack = 1'b1; bus.din_n = ~8'h04; cyc(1);
    bus.ack = 1'b0; bus.din_n = '1; cyc(2);
    bus.ack = 1'b1; cyc(1);
    bus.ack = 1'b0; cyc(1);

    phase = "reset_mid";
    pulse(8'h12);
    cyc(2);
    rst = 1'b1; cyc(1);
    rst = 1'b0; cyc(3);

    phase = "random";
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) bus.din_n[i] = ~bus.din_n[i];
      bus.ack  = 1'($urandom_range(0, 1));
      bus.ei_n = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 49) == 0) bus.mode = ~bus.mode;
      if ($urandom_range(0, 39) == 0) bus.mask = N'($urandom & $urandom & $urandom);
      rst = ($urandom_range(0, 399) == 0);
      cyc(1);
    end
    rst = 1'b0; bus.ack = 1'b0; bus.ei_n = 1'b0;
    cyc(3);

    phase = "drain";
    checks++;
    if (sb.size() > 1) begin
      errors++;
      $display("FAIL drain: %0d expected responses left, required at most 1", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prio_encoder_n.md
# prio_encoder_n

Parametrised, registered successor to the 8-to-3 priority encoder. It latches active-low request edges from N channels into a pending register. It then arbitrates among unmasked pending requests, in fixed or round-robin order, and presents one grant at a time as an active-low code with GS/EO cascade flags. The grant is held until the consumer acknowledges it. The block sits between raw interrupt/request lines and a single sequential consumer.

## Interface
- N, default 8: channel count, power of 2, 2..64
- W, default $clog2(N): code width (derived localparam, not overridable)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- ei_n  in  1  enable, active-low. High disables arbitration, outputs and ack.
- din_n  in  N  request lines, active-low. A falling edge sets the pending bit.
- mask  in  N  1 = channel excluded from arbitration (its pending bit is still captured)
- mode  in  1  0 = fixed priority (highest index wins), 1 = round-robin
- ack  in  1  consume current grant. Valid only while gs_n = 0, otherwise ignored.
- dout_n  out  W  inverted index of granted channel (~g); all ones when no grant
- gs_n  out  1  low = valid grant present
- eo_n  out  1  low = enabled and no eligible pending request (cascade enable to lower-priority stage)

## Operation
- din_q register (reset all ones) stores din_n each edge.
- rise[i] = din_q[i] & ~din_n[i].
- pending[i] is set at the edge where rise[i] = 1. It is cleared at the edge where ack is accepted and g = i.
- If a set and a clear hit the same bit on the same edge, set wins.
- eligible = pending & ~mask & ~(accepted-grant one-hot).
- Search order, mode 0: N-1 down to 0.
- Search order, mode 1: ptr-1 down to 0, then wrapping N-1 down to ptr (mod N). ptr resets to 0, so reset order equals fixed order.
- ptr <= g on every accepted ack, in both modes. A mode change takes effect at the next arbitration.
- Two-state output FSM:
  - IDLE (gs_n = 1) → GRANT at the edge where ei_n = 0 and eligible ≠ 0. That edge loads dout_n = ~pick.
  - GRANT → stays in GRANT, dout_n frozen, while ack = 0. New higher-priority requests do not preempt.
  - GRANT with ack = 1: re-arbitrate on the same edge. If eligible (excluding the accepted bit) ≠ 0, load the next grant (back-to-back, one grant per cycle). Otherwise go to IDLE.
- eo_n is registered each edge: 0 iff ei_n = 0 and eligible = 0 and not in GRANT.
- ei_n = 1 at an edge forces IDLE with dout_n = all ones, gs_n = 1, eo_n = 1.
  - pending and din_q keep updating; ptr is unchanged.
  - The in-flight grant is not consumed. It is re-arbitrated once ei_n returns low.

## Timing
- Reset values: dout_n = all ones, gs_n = 1, eo_n = 1, pending = 0, din_q = all ones, ptr = 0, state IDLE.
- Reset mid-grant discards all pending requests.
- Request latency: din_n[i] falls before edge t, pending[i] = 1 after edge t, gs_n = 0 / dout_n valid after edge t+1.
- Ack latency: ack high at edge t, next grant (or gs_n = 1) visible after edge t.
- Sustained throughput: one grant per cycle.
- A level held low does not re-request. A new falling edge is required.
- Masked pending bits become eligible at the first edge after the mask bit clears.

## Structure
- Shared package prio_pkg:
  - function enc_n(idx), returns ~idx
  - state enum {IDLE, GRANT}
  - constant W_OF(N) = $clog2(N)
- Sub-module prio_pick:
  - purely combinational: inputs req[N-1:0] and ptr[W-1:0]; outputs hit and idx[W-1:0]
  - rotate-search in descending order, mod N
  - mode 0 drives ptr = 0
- Top level holds din_q, pending, ptr, state and the output registers.

## Test plan
Each scenario uses N = 8.
- Reset/idle: rst for 2 cycles → dout_n = 3'b111, gs_n = 1, eo_n = 1. Then ei_n = 0 with no requests → eo_n = 0 after 1 edge.
- Fixed priority: mode = 0, din_n 8'hFF → 8'b0101_0101.
  - After 2 edges, dout_n = 3'b000 (ch 7), gs_n = 0.
  - Hold ack high → grants 7, 5, 3, 1 on consecutive edges, then gs_n = 1, eo_n = 0.
- Hold/no preempt: grant ch 3 active, ack low, new edge on ch 6.
  - dout_n stays 3'b100.
  - After ack, dout_n = 3'b001 (ch 6).
- Round-robin: mode = 1, pending {7, 0}.
  - Grant 7, ack, re-pulse ch 7 → next grant is 0 (dout_n = 3'b111), then 7.
- Mask: mask = 8'h80, pending {7, 0} → grant 0. Clear mask → ch 7 granted on the edge of ch 0's ack.
- Disable/simultaneous: ei_n = 1 mid-grant on ch 5 → next edge 3'b111 / gs_n = 1 / eo_n = 1, pending retained.
  - ei_n = 0 → ch 5 re-granted after 1 edge.
  - Ack of ch 2 on the same edge as a new falling edge on ch 2 → pending[2] stays set.
